accelerator_state_vector_iterator: RTL and testbench
====================================================

Name: accelerator_state_vector_iterator

Overview:
- Iterative discrete-time state-space engine for the NTM accelerator state subsystem.
- Computes x(k+1) = A·x(k) + B·u(k) for K steps, using runtime sizes N (states) and M (inputs) bounded by parameters.
- Each step is built from sequential MAC operations on stored A, B and x; u(k) is streamed in per step and x(k+1) is streamed out per step.
- Adds a matrix-hold mode for repeated runs and signed fixed-point scaling.

Parameters:
- DATA_SIZE, 64, element width (signed two's complement).
- FRACTION_SIZE, 0, fixed-point fraction bits; each product is arithmetically shifted right by this amount.
- MAX_N, 4, maximum state dimension.
- MAX_M, 4, maximum input dimension.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- START  in  1  begin run (sampled only in IDLE).
- HOLD_MATRICES_IN  in  1  sampled with START; 1 = reuse stored A/B.
- READY  out  1  one-cycle pulse at run end.
- ERROR  out  1  one-cycle pulse, coincident with READY, on rejected run.
- SIZE_N_IN  in  DATA_SIZE  state dimension N.
- SIZE_M_IN  in  DATA_SIZE  input dimension M.
- SIZE_K_IN  in  DATA_SIZE  step count K.
- DATA_A_IN_ENABLE  in  1  A element valid (row-major).
- DATA_B_IN_ENABLE  in  1  B element valid (row-major).
- DATA_X_IN_ENABLE  in  1  x(0) element valid.
- DATA_U_IN_ENABLE  in  1  u(k) element valid.
- DATA_A_IN  in  DATA_SIZE  A element data.
- DATA_B_IN  in  DATA_SIZE  B element data.
- DATA_X_IN  in  DATA_SIZE  x(0) element data.
- DATA_U_IN  in  DATA_SIZE  u(k) element data.
- DATA_U_IN_REQUEST  out  1  high while the block is waiting for u(k).
- DATA_X_OUT_ENABLE  out  1  x(k+1) element valid.
- DATA_X_OUT_LAST  out  1  high with the final element of each step.
- DATA_X_OUT  out  DATA_SIZE  x(k+1) element data.

Behaviour:
- Clocking and reset: one clock, CLK. RST is asynchronous and active-high.
- Reset response: state goes to IDLE; all outputs go to 0; counters clear; the matrices-valid flag clears. Array contents are don't-care.
- Reset mid-operation aborts the run with no READY.
- States: IDLE → LOAD_A → LOAD_B → LOAD_X → LOAD_U → COMPUTE → OUTPUT. After OUTPUT, go to LOAD_U for the next step, or to IDLE after step K-1.
- IDLE: on START, latch N, M, K and HOLD.
- Error path: the run is rejected if N=0, K=0, N>MAX_N, M>MAX_M, or (HOLD=1 and matrices-valid=0). On rejection, the next cycle pulses READY and ERROR together and the block stays in IDLE.
- HOLD=1 with valid matrices: skip LOAD_A and LOAD_B. The latched N and M must match the stored sizes, otherwise the run is rejected as an error.
- Loads:
  - One element is accepted per cycle while the matching enable is high in the matching state. Enables arriving in any other state are ignored.
  - LOAD_A takes N·N elements; LOAD_B takes N·M elements; LOAD_X takes N elements.
  - Matrices-valid is set when LOAD_B completes.
  - M=0: skip LOAD_B and LOAD_U.
- LOAD_U: DATA_U_IN_REQUEST=1; takes M elements.
- COMPUTE:
  - One MAC per cycle, row i from 0 to N-1, accumulating over the A terms (j<N) and then the B terms (j<M). This takes exactly N·(N+M) cycles.
  - The result goes to a shadow x_next buffer; x is unchanged during COMPUTE.
- Arithmetic:
  - Each product is a 2·DATA_SIZE signed value, arithmetically shifted right by FRACTION_SIZE.
  - The accumulator is 2·DATA_SIZE and wraps modulo 2^(2·DATA_SIZE).
  - The stored result is the low DATA_SIZE bits (wrap, no saturation).
- Latency: the first DATA_X_OUT_ENABLE occurs exactly N·(N+M)+1 cycles after the cycle the last u element is accepted. If M=0, this is measured from the last x(0) element, or from the last output element of the previous step.
- OUTPUT:
  - N consecutive cycles with DATA_X_OUT_ENABLE=1, elements in index order; DATA_X_OUT_LAST is set on element N-1.
  - x is updated from x_next as the elements are emitted.
  - DATA_X_OUT holds its last value when not enabled.
- Run end: READY pulses for one cycle in the cycle after the final output element of step K-1, then the block returns to IDLE.
- START while not in IDLE is ignored. Simultaneous START and READY: the START is ignored.
- SIZE_*_IN are used only at START; later changes have no effect on the run.

Test Plan:
- Scalar run (DATA_SIZE=64, FRACTION_SIZE=0): N=1, M=1, K=3, A=2, B=1, x0=1, u=1,1,1 → outputs 3, 7, 15, each with LAST=1. First output arrives 3 cycles after u is accepted. READY pulses once and ERROR stays 0.
- Matrix run: N=2, M=1, K=2, A=[[1,1],[0,1]], B=[0,1], x0=[0,0], u=1,1 → x1=[0,1], x2=[1,2]. LAST is set on the second element of each step, and DATA_U_IN_REQUEST rises twice.
- Rejections: N=0 → READY and ERROR both pulse the cycle after START, with no DATA_X_OUT_ENABLE. N=MAX_N+1 gives the same. HOLD=1 immediately after reset gives the same.
- Hold mode: after the matrix run, START with HOLD=1, N=2, M=1, K=1, x0=[1,0], u=0 → no A/B loading and output [1,0]. The same run with N=3 → ERROR.
- Fixed point and wrap:
  - Instance with FRACTION_SIZE=8: N=1, M=0, K=2, A=0x80, x0=0x100 → outputs 0x80, 0x40.
  - 64-bit instance with FRACTION_SIZE=0: A=2, x0=0x4000000000000000, K=1 → output 0x8000000000000000.
- Robustness: assert RST midway through COMPUTE → all outputs 0 immediately and no READY. Pulse START and all enables during COMPUTE → results unchanged from the clean run. A subsequent fresh run gives correct results.

Source files
------------

// File: rtl/accelerator_state_vector_iterator.sv
// Iterative state-space engine: x(k+1) = A*x(k) + B*u(k) for K steps,
// one MAC per cycle, with matrix hold and signed fixed-point scaling.
module accelerator_state_vector_iterator #(
    parameter int DATA_SIZE     = 64,
    parameter int FRACTION_SIZE = 0,
    parameter int MAX_N         = 4,
    parameter int MAX_M         = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 HOLD_MATRICES_IN,
    output logic                 READY,
    output logic                 ERROR,
    input  logic [DATA_SIZE-1:0] SIZE_N_IN,
    input  logic [DATA_SIZE-1:0] SIZE_M_IN,
    input  logic [DATA_SIZE-1:0] SIZE_K_IN,
    input  logic                 DATA_A_IN_ENABLE,
    input  logic                 DATA_B_IN_ENABLE,
    input  logic                 DATA_X_IN_ENABLE,
    input  logic                 DATA_U_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] DATA_A_IN,
    input  logic [DATA_SIZE-1:0] DATA_B_IN,
    input  logic [DATA_SIZE-1:0] DATA_X_IN,
    input  logic [DATA_SIZE-1:0] DATA_U_IN,
    output logic                 DATA_U_IN_REQUEST,
    output logic                 DATA_X_OUT_ENABLE,
    output logic                 DATA_X_OUT_LAST,
    output logic [DATA_SIZE-1:0] DATA_X_OUT
);

    localparam int NW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int MW = (MAX_M > 1) ? $clog2(MAX_M) : 1;
    localparam int AW = 2 * DATA_SIZE;

    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_B, LOAD_X, LOAD_U, COMPUTE, OUTPUT
    } state_t;

    state_t               state_q, state_d;
    logic [NW-1:0]        i_q, i_d;
    logic [NW-1:0]        ja_q, ja_d;
    logic [MW-1:0]        jb_q, jb_d;
    logic                 bph_q, bph_d;
    logic [NW-1:0]        nm1_q, nm1_d;
    logic [MW-1:0]        mm1_q, mm1_d;
    logic                 mz_q, mz_d;
    logic [DATA_SIZE-1:0] k_q, k_d;
    logic [DATA_SIZE-1:0] s_q, s_d;
    logic                 mvalid_q, mvalid_d;
    logic [DATA_SIZE-1:0] hn_q, hn_d;
    logic [DATA_SIZE-1:0] hm_q, hm_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [DATA_SIZE-1:0] dout_q, dout_d;
    logic                 ready_q, ready_d;
    logic                 error_q, error_d;

    logic [DATA_SIZE-1:0] a_q  [MAX_N][MAX_N];
    logic [DATA_SIZE-1:0] b_q  [MAX_N][MAX_M];
    logic [DATA_SIZE-1:0] x_q  [MAX_N];
    logic [DATA_SIZE-1:0] u_q  [MAX_M];
    logic [DATA_SIZE-1:0] xn_q [MAX_N];

    logic [DATA_SIZE-1:0] opa, opb;
    logic signed [AW-1:0] ea, eb, prod, sum;
    logic                 first_term, last_term, reject;

    // A terms of a row come first, then the B terms (bph_q high)
    always_comb begin
        opa = bph_q ? b_q[i_q][jb_q] : a_q[i_q][ja_q];
        opb = bph_q ? u_q[jb_q] : x_q[ja_q];
        ea = {{DATA_SIZE{opa[DATA_SIZE-1]}}, opa};
        eb = {{DATA_SIZE{opb[DATA_SIZE-1]}}, opb};
        prod = (ea * eb) >>> FRACTION_SIZE;
        first_term = !bph_q && (ja_q == '0);
        last_term = bph_q ? (jb_q == mm1_q)
                          : ((ja_q == nm1_q) && mz_q);
        sum = (first_term ? {AW{1'b0}} : acc_q) + prod;
    end

    always_comb begin
        reject = (SIZE_N_IN == '0) || (SIZE_K_IN == '0)
              || (SIZE_N_IN > DATA_SIZE'(MAX_N))
              || (SIZE_M_IN > DATA_SIZE'(MAX_M));
        if (HOLD_MATRICES_IN && (!mvalid_q || SIZE_N_IN != hn_q
                                 || SIZE_M_IN != hm_q))
            reject = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        ja_d     = ja_q;
        jb_d     = jb_q;
        bph_d    = bph_q;
        nm1_d    = nm1_q;
        mm1_d    = mm1_q;
        mz_d     = mz_q;
        k_d      = k_q;
        s_d      = s_q;
        mvalid_d = mvalid_q;
        hn_d     = hn_q;
        hm_d     = hm_q;
        acc_d    = acc_q;
        dout_d   = dout_q;
        ready_d  = 1'b0;
        error_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START && !ready_q) begin
                    if (reject) begin
                        ready_d = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        nm1_d = NW'(SIZE_N_IN - 1'b1);
                        mm1_d = MW'(SIZE_M_IN - 1'b1);
                        mz_d  = (SIZE_M_IN == '0);
                        k_d   = SIZE_K_IN;
                        s_d   = '0;
                        i_d   = '0;
                        ja_d  = '0;
                        jb_d  = '0;
                        bph_d = 1'b0;
                        if (HOLD_MATRICES_IN) begin
                            state_d = LOAD_X;
                        end else begin
                            state_d  = LOAD_A;
                            mvalid_d = 1'b0;
                            hn_d     = SIZE_N_IN;
                            hm_d     = SIZE_M_IN;
                        end
                    end
                end
            end
            LOAD_A: begin
                if (DATA_A_IN_ENABLE) begin
                    if (ja_q == nm1_q) begin
                        ja_d = '0;
                        if (i_q == nm1_q) begin
                            i_d = '0;
                            if (mz_q) begin
                                state_d  = LOAD_X;
                                mvalid_d = 1'b1;
                            end else begin
                                state_d = LOAD_B;
                            end
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        ja_d = ja_q + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (DATA_B_IN_ENABLE) begin
                    if (jb_q == mm1_q) begin
                        jb_d = '0;
                        if (i_q == nm1_q) begin
                            i_d      = '0;
                            state_d  = LOAD_X;
                            mvalid_d = 1'b1;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        jb_d = jb_q + 1'b1;
                    end
                end
            end
            LOAD_X: begin
                if (DATA_X_IN_ENABLE) begin
                    if (i_q == nm1_q) begin
                        i_d     = '0;
                        ja_d    = '0;
                        jb_d    = '0;
                        bph_d   = 1'b0;
                        state_d = mz_q ? COMPUTE : LOAD_U;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            LOAD_U: begin
                if (DATA_U_IN_ENABLE) begin
                    if (jb_q == mm1_q) begin
                        jb_d    = '0;
                        state_d = COMPUTE;
                    end else begin
                        jb_d = jb_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                acc_d = sum;
                if (last_term) begin
                    bph_d = 1'b0;
                    ja_d  = '0;
                    jb_d  = '0;
                    if (i_q == nm1_q) begin
                        i_d     = '0;
                        state_d = OUTPUT;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else if (!bph_q && ja_q == nm1_q) begin
                    bph_d = 1'b1;
                    jb_d  = '0;
                end else if (bph_q) begin
                    jb_d = jb_q + 1'b1;
                end else begin
                    ja_d = ja_q + 1'b1;
                end
            end
            OUTPUT: begin
                dout_d = xn_q[i_q];
                if (i_q == nm1_q) begin
                    i_d = '0;
                    if (s_q == k_q - 1'b1) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end else begin
                        s_d     = s_q + 1'b1;
                        state_d = mz_q ? COMPUTE : LOAD_U;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            i_q      <= '0;
            ja_q     <= '0;
            jb_q     <= '0;
            bph_q    <= 1'b0;
            nm1_q    <= '0;
            mm1_q    <= '0;
            mz_q     <= 1'b0;
            k_q      <= '0;
            s_q      <= '0;
            mvalid_q <= 1'b0;
            hn_q     <= '0;
            hm_q     <= '0;
            acc_q    <= '0;
            dout_q   <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            ja_q     <= ja_d;
            jb_q     <= jb_d;
            bph_q    <= bph_d;
            nm1_q    <= nm1_d;
            mm1_q    <= mm1_d;
            mz_q     <= mz_d;
            k_q      <= k_d;
            s_q      <= s_d;
            mvalid_q <= mvalid_d;
            hn_q     <= hn_d;
            hm_q     <= hm_d;
            acc_q    <= acc_d;
            dout_q   <= dout_d;
            ready_q  <= ready_d;
            error_q  <= error_d;
        end
    end

    // x_next is a shadow copy; x only follows it as elements are emitted
    always_ff @(posedge CLK) begin
        if (state_q == LOAD_A && DATA_A_IN_ENABLE)
            a_q[i_q][ja_q] <= DATA_A_IN;
        if (state_q == LOAD_B && DATA_B_IN_ENABLE)
            b_q[i_q][jb_q] <= DATA_B_IN;
        if (state_q == LOAD_X && DATA_X_IN_ENABLE)
            x_q[i_q] <= DATA_X_IN;
        if (state_q == LOAD_U && DATA_U_IN_ENABLE)
            u_q[jb_q] <= DATA_U_IN;
        if (state_q == COMPUTE && last_term)
            xn_q[i_q] <= sum[DATA_SIZE-1:0];
        if (state_q == OUTPUT)
            x_q[i_q] <= xn_q[i_q];
    end

    assign READY             = ready_q;
    assign ERROR             = error_q;
    assign DATA_U_IN_REQUEST = (state_q == LOAD_U);
    assign DATA_X_OUT_ENABLE = (state_q == OUTPUT);
    assign DATA_X_OUT_LAST   = (state_q == OUTPUT) && (i_q == nm1_q);
    assign DATA_X_OUT        = (state_q == OUTPUT) ? xn_q[i_q] : dout_q;

endmodule

// File: tb/tb_accelerator_state_vector_iterator.sv
// Directed self-checking bench for accelerator_state_vector_iterator.
// Main instance is 64-bit integer; a second one uses 8 fraction bits.
module tb_accelerator_state_vector_iterator;

    localparam int D = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start, hold, a_en, b_en, x_en, u_en;
    logic [D-1:0] sn, sm, sk, a_d, b_d, x_d, u_d;
    logic         ready, error, u_req, o_en, o_last;
    logic [D-1:0] o_d;

    logic         f_start, f_a_en, f_x_en;
    logic [D-1:0] f_a_d, f_x_d;
    logic         f_ready, f_error, f_u_req, f_o_en, f_o_last;
    logic [D-1:0] f_o_d;

    accelerator_state_vector_iterator #(
        .DATA_SIZE(64), .FRACTION_SIZE(0), .MAX_N(4), .MAX_M(4)
    ) dut (
        .CLK(clk), .RST(rst), .START(start), .HOLD_MATRICES_IN(hold),
        .READY(ready), .ERROR(error),
        .SIZE_N_IN(sn), .SIZE_M_IN(sm), .SIZE_K_IN(sk),
        .DATA_A_IN_ENABLE(a_en), .DATA_B_IN_ENABLE(b_en),
        .DATA_X_IN_ENABLE(x_en), .DATA_U_IN_ENABLE(u_en),
        .DATA_A_IN(a_d), .DATA_B_IN(b_d),
        .DATA_X_IN(x_d), .DATA_U_IN(u_d),
        .DATA_U_IN_REQUEST(u_req), .DATA_X_OUT_ENABLE(o_en),
        .DATA_X_OUT_LAST(o_last), .DATA_X_OUT(o_d)
    );

    accelerator_state_vector_iterator #(
        .DATA_SIZE(64), .FRACTION_SIZE(8), .MAX_N(4), .MAX_M(4)
    ) dutf (
        .CLK(clk), .RST(rst), .START(f_start), .HOLD_MATRICES_IN(1'b0),
        .READY(f_ready), .ERROR(f_error),
        .SIZE_N_IN(64'd1), .SIZE_M_IN(64'd0), .SIZE_K_IN(64'd2),
        .DATA_A_IN_ENABLE(f_a_en), .DATA_B_IN_ENABLE(1'b0),
        .DATA_X_IN_ENABLE(f_x_en), .DATA_U_IN_ENABLE(1'b0),
        .DATA_A_IN(f_a_d), .DATA_B_IN(64'd0),
        .DATA_X_IN(f_x_d), .DATA_U_IN(64'd0),
        .DATA_U_IN_REQUEST(f_u_req), .DATA_X_OUT_ENABLE(f_o_en),
        .DATA_X_OUT_LAST(f_o_last), .DATA_X_OUT(f_o_d)
    );

    int nchk = 0;
    int nfail = 0;

    int cyc = 0, nready = 0, nerr = 0, nreq = 0;
    int fready = 0, ferr = 0, fxc = 0;
    logic req_prev = 1'b0;
    logic [D-1:0] oq[$], fq[$];
    logic         lq[$], flq[$];
    int           oc[$], uc[$], fc[$];

    always @(negedge clk) begin
        cyc++;
        if (u_en && u_req) uc.push_back(cyc);
        if (o_en) begin
            oq.push_back(o_d);
            lq.push_back(o_last);
            oc.push_back(cyc);
        end
        if (ready) nready++;
        if (error) nerr++;
        if (u_req && !req_prev) nreq++;
        req_prev = u_req;
        if (f_x_en) fxc = cyc;
        if (f_o_en) begin
            fq.push_back(f_o_d);
            flq.push_back(f_o_last);
            fc.push_back(cyc);
        end
        if (f_ready) fready++;
        if (f_error) ferr++;
    end

    logic [D-1:0] av[16], bv[16], xv[4], uv[16], ev[8];
    logic         el[8];

    task automatic chk(input string tag, input logic [D-1:0] obs,
                       input logic [D-1:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n, input int m, input int k,
                             input logic h);
        start = 1'b1;
        hold  = h;
        sn    = D'(n);
        sm    = D'(m);
        sk    = D'(k);
        tick();
        start = 1'b0;
        hold  = 1'b0;
    endtask

    task automatic load_mats(input int n, input int m, input logic h);
        if (!h) begin
            for (int i = 0; i < n * n; i++) begin
                a_en = 1'b1; a_d = av[i]; tick();
            end
            a_en = 1'b0;
            for (int i = 0; i < n * m; i++) begin
                b_en = 1'b1; b_d = bv[i]; tick();
            end
            b_en = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            x_en = 1'b1; x_d = xv[i]; tick();
        end
        x_en = 1'b0;
    endtask

    task automatic feed_step(input int m, input int s);
        int t = 0;
        while (!u_req && t < 100) begin
            tick();
            t++;
        end
        chk("u_req_wait", D'(u_req), 64'd1);
        for (int j = 0; j < m; j++) begin
            u_en = 1'b1; u_d = uv[s * m + j]; tick();
        end
        u_en = 1'b0;
    endtask

    task automatic wait_ready(input int snap);
        int t = 0;
        while (nready == snap && t < 300) begin
            tick();
            t++;
        end
        chk("ready_wait", D'(nready - snap), 64'd1);
    endtask

    task automatic chk_outs(input string tag, input int base, input int n);
        chk({tag, "_count"}, D'(oq.size() - base), D'(n));
        for (int i = 0; i < n && base + i < oq.size(); i++) begin
            chk($sformatf("%s_x%0d", tag, i), oq[base + i], ev[i]);
            chk($sformatf("%s_last%0d", tag, i), D'(lq[base + i]),
                D'(el[i]));
        end
    endtask

    task automatic reject_chk(input string tag, input int n, input int m,
                              input int k, input logic h);
        int ob = oq.size();
        start_run(n, m, k, h);
        @(negedge clk);
        chk({tag, "_ready"}, D'(ready), 64'd1);
        chk({tag, "_error"}, D'(error), 64'd1);
        tick();
        @(negedge clk);
        chk({tag, "_ready_clr"}, D'({ready, error, u_req}), 64'd0);
        chk({tag, "_no_out"}, D'(oq.size() - ob), 64'd0);
        tick();
    endtask

    initial begin
        int ob, ub, rb, eb, rq, t;
        start = 0; hold = 0; sn = 0; sm = 0; sk = 0;
        a_en = 0; b_en = 0; x_en = 0; u_en = 0;
        a_d = 0; b_d = 0; x_d = 0; u_d = 0;
        f_start = 0; f_a_en = 0; f_x_en = 0; f_a_d = 0; f_x_d = 0;

        @(negedge clk);
        chk("rst_ready", D'(ready), 64'd0);
        chk("rst_error", D'(error), 64'd0);
        chk("rst_ureq", D'(u_req), 64'd0);
        chk("rst_oen", D'(o_en), 64'd0);
        chk("rst_last", D'(o_last), 64'd0);
        chk("rst_dout", o_d, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        reject_chk("rej_hold_nomat", 1, 1, 1, 1'b1);
        reject_chk("rej_n0", 0, 1, 1, 1'b0);
        reject_chk("rej_n5", 5, 1, 1, 1'b0);
        reject_chk("rej_k0", 1, 1, 0, 1'b0);
        reject_chk("rej_m5", 1, 5, 1, 1'b0);

        // scalar: x = 2x + u, x0=1, u=1 -> 3, 7, 15
        av[0] = 2; bv[0] = 1; xv[0] = 1;
        uv[0] = 1; uv[1] = 1; uv[2] = 1;
        ob = oq.size(); ub = uc.size(); rb = nready; eb = nerr;
        start_run(1, 1, 3, 1'b0);
        load_mats(1, 1, 1'b0);
        for (int s = 0; s < 3; s++) feed_step(1, s);
        wait_ready(rb);
        ev[0] = 3; ev[1] = 7; ev[2] = 15;
        el[0] = 1; el[1] = 1; el[2] = 1;
        chk_outs("scalar", ob, 3);
        if (oc.size() > ob && uc.size() > ub)
            chk("scalar_latency", D'(oc[ob] - uc[ub]), 64'd3);
        chk("scalar_err", D'(nerr - eb), 64'd0);

        // 2x2 integrator chain
        av[0] = 1; av[1] = 1; av[2] = 0; av[3] = 1;
        bv[0] = 0; bv[1] = 1; xv[0] = 0; xv[1] = 0;
        uv[0] = 1; uv[1] = 1;
        ob = oq.size(); ub = uc.size(); rb = nready; rq = nreq;
        start_run(2, 1, 2, 1'b0);
        load_mats(2, 1, 1'b0);
        for (int s = 0; s < 2; s++) feed_step(1, s);
        wait_ready(rb);
        ev[0] = 0; ev[1] = 1; ev[2] = 1; ev[3] = 2;
        el[0] = 0; el[1] = 1; el[2] = 0; el[3] = 1;
        chk_outs("matrix", ob, 4);
        chk("matrix_ureq_rises", D'(nreq - rq), 64'd2);
        if (oc.size() > ob && uc.size() > ub)
            chk("matrix_latency", D'(oc[ob] - uc[ub]), 64'd7);

        // reuse stored A/B
        xv[0] = 1; xv[1] = 0; uv[0] = 0;
        ob = oq.size(); rb = nready; eb = nerr;
        start_run(2, 1, 1, 1'b1);
        load_mats(2, 1, 1'b1);
        feed_step(1, 0);
        wait_ready(rb);
        ev[0] = 1; ev[1] = 0; el[0] = 0; el[1] = 1;
        chk_outs("hold", ob, 2);
        chk("hold_err", D'(nerr - eb), 64'd0);
        reject_chk("rej_hold_size", 3, 1, 1, 1'b1);

        // fraction bits 8: 0x80*0x100 >> 8 = 0x80, then 0x80*0x80 >> 8
        f_start = 1'b1; tick(); f_start = 1'b0;
        f_a_en = 1'b1; f_a_d = 64'h80; tick(); f_a_en = 1'b0;
        f_x_en = 1'b1; f_x_d = 64'h100; tick(); f_x_en = 1'b0;
        t = 0;
        while (fready == 0 && t < 100) begin
            tick();
            t++;
        end
        chk("fix_ready", D'(fready), 64'd1);
        chk("fix_count", D'(fq.size()), 64'd2);
        if (fq.size() == 2) begin
            chk("fix_x0", fq[0], 64'h80);
            chk("fix_x1", fq[1], 64'h40);
            chk("fix_last", D'({flq[0], flq[1]}), 64'd3);
            chk("fix_lat_x", D'(fc[0] - fxc), 64'd2);
            chk("fix_lat_step", D'(fc[1] - fc[0]), 64'd2);
        end
        chk("fix_err", D'(ferr), 64'd0);

        // wrap into the sign bit
        av[0] = 2; xv[0] = 64'h4000000000000000;
        ob = oq.size(); rb = nready;
        start_run(1, 0, 1, 1'b0);
        load_mats(1, 0, 1'b0);
        wait_ready(rb);
        ev[0] = 64'h8000000000000000; el[0] = 1;
        chk_outs("wrap", ob, 1);
        @(negedge clk);
        chk("dout_hold", o_d, 64'h8000000000000000);
        tick();

        // reset mid-COMPUTE
        av[0] = 1; av[1] = 1; av[2] = 0; av[3] = 1;
        bv[0] = 0; bv[1] = 1; xv[0] = 0; xv[1] = 0;
        uv[0] = 1; uv[1] = 1;
        ob = oq.size(); rb = nready;
        start_run(2, 1, 2, 1'b0);
        load_mats(2, 1, 1'b0);
        feed_step(1, 0);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("abort_outs", D'({ready, error, u_req, o_en, o_last}), 64'd0);
        chk("abort_dout", o_d, 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("abort_no_ready", D'(nready - rb), 64'd0);
        chk("abort_no_out", D'(oq.size() - ob), 64'd0);

        // START and enables pulsed during COMPUTE are ignored
        ob = oq.size(); rb = nready;
        start_run(2, 1, 2, 1'b0);
        load_mats(2, 1, 1'b0);
        feed_step(1, 0);
        tick();
        start = 1; hold = 1; sn = 3; sm = 3; sk = 9;
        a_en = 1; b_en = 1; x_en = 1; u_en = 1;
        a_d = 64'hdead; b_d = 64'hbeef; x_d = 64'h55; u_d = 64'h77;
        tick();
        start = 0; hold = 0;
        a_en = 0; b_en = 0; x_en = 0; u_en = 0;
        feed_step(1, 1);
        wait_ready(rb);
        ev[0] = 0; ev[1] = 1; ev[2] = 1; ev[3] = 2;
        el[0] = 0; el[1] = 1; el[2] = 0; el[3] = 1;
        chk_outs("noise", ob, 4);

        // fresh run after the disturbances
        av[0] = 2; bv[0] = 1; xv[0] = 1; uv[0] = 1;
        ob = oq.size(); rb = nready; eb = nerr;
        start_run(1, 1, 1, 1'b0);
        load_mats(1, 1, 1'b0);
        feed_step(1, 0);
        wait_ready(rb);
        ev[0] = 3; el[0] = 1;
        chk_outs("fresh", ob, 1);
        chk("fresh_err", D'(nerr - eb), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
